// File: rtl/spi_nor_responder.sv
// spi_nor_responder: byte-wide SPI NOR-flash target with a word-organised
// array and NOR program semantics (programming can only clear bits).
// Optional feature macro NOR_WEL_EN: adds the write-enable latch, the
// WREN (8'h06) and READ_STATUS (8'h05) commands, and gates PROGRAM/ERASE on it.
// MEM_DEPTH is expected to equal 2**ADDR_W.
module spi_nor_responder #(
    parameter int          MEM_DEPTH = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] ERASE_VAL = 32'hFFFF_FFFF
) (
    input  logic       p_clk,
    input  logic       p_reset_n,
    input  logic       s_clk,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso,
    output logic       s_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_PROG  = 8'h02;
    localparam logic [7:0] CMD_ERASE = 8'h20;
`ifdef NOR_WEL_EN
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
`endif

    state_t              state_reg, state_next;
    logic                s_clk_q_reg;
    logic [3:0]          cnt_reg;
    logic [7:0]          cmd_reg;
    logic [15:0]         addr_reg;       // address bytes 2 and 3; byte 4 arrives live
    logic [31:0]         data_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic                oor_reg;
    logic                prog_pend_reg;
    logic                erase_pend_reg;
    logic [31:0]         rd_word_reg;
    logic [7:0]          s_miso_reg;
    logic [31:0]         mem [MEM_DEPTH];

    logic                rise;
    logic                byte_ev;
    logic                byte4_ev;
    logic                byte8_ev;
    logic [23:0]         addr_full;
    logic [ADDR_W-1:0]   idx_next;
    logic                oor_next;
    logic                wel_ok;
    logic [31:0]         rd_src;
    logic                unused_bits;

    assign rise      = s_clk & ~s_clk_q_reg;
    assign byte_ev   = rise & ~s_css;
    assign byte4_ev  = byte_ev && (state_reg == ST_ADDR) && (cnt_reg == 4'd3);
    assign byte8_ev  = byte_ev && (state_reg == ST_DATA) && (cnt_reg == 4'd7);
    assign addr_full = {addr_reg, s_mosi};
    assign idx_next  = addr_full[ADDR_W+1:2];
    assign oor_next  = |addr_full[23:ADDR_W+2];
    assign rd_src    = oor_reg ? ERASE_VAL : rd_word_reg;
    assign unused_bits = ^addr_full[1:0];

    assign s_miso = s_miso_reg;
    assign s_busy = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

    // Frame state register.
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) state_reg <= ST_IDLE;
        else            state_reg <= state_next;
    end

    // Frame sequencing; deselect wins over any byte arriving in the same cycle.
    always_comb begin
        state_next = state_reg;
        if (s_css) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_CMD;
                ST_CMD:  if (byte_ev)  state_next = ST_ADDR;
                ST_ADDR: if (byte4_ev) state_next = ST_DATA;
                ST_DATA: if (byte8_ev) state_next = ST_DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    // Byte capture, byte counting and commit-request generation.
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            s_clk_q_reg    <= 1'b0;
            cnt_reg        <= 4'd0;
            cmd_reg        <= 8'h00;
            addr_reg       <= 16'h0000;
            data_reg       <= 32'h0000_0000;
            idx_reg        <= '0;
            oor_reg        <= 1'b0;
            prog_pend_reg  <= 1'b0;
            erase_pend_reg <= 1'b0;
        end else begin
            s_clk_q_reg    <= s_clk;
            prog_pend_reg  <= 1'b0;
            erase_pend_reg <= 1'b0;
            if (s_css) begin
                cnt_reg <= 4'd0;
            end else if (state_reg == ST_IDLE) begin
                cnt_reg <= 4'd0;
                cmd_reg <= 8'h00;
            end else if (byte_ev && state_reg != ST_DONE) begin
                cnt_reg <= cnt_reg + 4'd1;
                case (state_reg)
                    ST_CMD:  cmd_reg  <= s_mosi;
                    ST_ADDR: addr_reg <= {addr_reg[7:0], s_mosi};
                    ST_DATA: data_reg <= {data_reg[23:0], s_mosi};
                    default: ;
                endcase
            end
            if (byte4_ev) begin
                idx_reg        <= idx_next;
                oor_reg        <= oor_next;
                erase_pend_reg <= (cmd_reg == CMD_ERASE) && !oor_next && wel_ok;
            end
            if (byte8_ev) begin
                prog_pend_reg <= (cmd_reg == CMD_PROG) && !oor_reg && wel_ok;
            end
        end
    end

    // Registered array read at the last address byte; also supplies the old
    // word for the AND-merge of a later PROGRAM commit in the same frame.
    always_ff @(posedge p_clk) begin
        if (byte4_ev) rd_word_reg <= mem[idx_next];
    end

    // Array update: erase after the address, AND-merge one cycle after byte 8.
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= ERASE_VAL;
        end else if (erase_pend_reg) begin
            mem[idx_reg] <= ERASE_VAL;
        end else if (prog_pend_reg) begin
            mem[idx_reg] <= rd_word_reg & data_reg;
        end
    end

`ifdef NOR_WEL_EN
    logic wel_reg;
    assign wel_ok = wel_reg;

    // Write-enable latch: set by WREN, dropped when any PROGRAM/ERASE frame ends.
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            wel_reg <= 1'b0;
        end else if (prog_pend_reg || erase_pend_reg) begin
            wel_reg <= 1'b0;
        end else if (s_css && state_reg != ST_IDLE &&
                     (cmd_reg == CMD_PROG || cmd_reg == CMD_ERASE)) begin
            wel_reg <= 1'b0;
        end else if (byte_ev && state_reg == ST_CMD && s_mosi == CMD_WREN) begin
            wel_reg <= 1'b1;
        end
    end
`else
    assign wel_ok = 1'b1;
`endif

    // Output byte: read data walks MSB to LSB through the data phase, else zero.
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            s_miso_reg <= 8'h00;
        end else if (state_reg == ST_DATA && cmd_reg == CMD_READ) begin
            case (cnt_reg[1:0])
                2'd0:    s_miso_reg <= rd_src[31:24];
                2'd1:    s_miso_reg <= rd_src[23:16];
                2'd2:    s_miso_reg <= rd_src[15:8];
                default: s_miso_reg <= rd_src[7:0];
            endcase
        end
`ifdef NOR_WEL_EN
        else if (state_reg == ST_ADDR && cmd_reg == CMD_RDSR) begin
            s_miso_reg <= {7'b0, wel_reg};
        end
`endif
        else begin
            s_miso_reg <= 8'h00;
        end
    end

endmodule

// File: tb/tb_spi_nor_responder.sv
// tb_spi_nor_responder: directed and random SPI frames checked against a
// frame-level model of the flash array (and write-enable latch when built in).
module tb_spi_nor_responder;

`ifdef NOR_WEL_EN
    localparam bit WEL_EN = 1'b1;
`else
    localparam bit WEL_EN = 1'b0;
`endif

    logic       p_clk = 1'b0;
    logic       p_reset_n = 1'b0;
    logic       s_clk = 1'b0;
    logic       s_css = 1'b1;
    logic [7:0] s_mosi = 8'h00;
    logic [7:0] s_miso;
    logic       s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [16];
    logic        ref_wel;

    spi_nor_responder dut (
        .p_clk     (p_clk),
        .p_reset_n (p_reset_n),
        .s_clk     (s_clk),
        .s_css     (s_css),
        .s_mosi    (s_mosi),
        .s_miso    (s_miso),
        .s_busy    (s_busy)
    );

    always #5 p_clk = ~p_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected s_miso after the k-th byte of a frame, from the pre-frame model.
    function automatic logic [7:0] exp_miso(input logic [7:0] cmd, input logic [23:0] addr,
                                            input int k, input logic pre_wel);
        logic [31:0] word;
        word = (addr[23:6] != 0) ? 32'hFFFF_FFFF : ref_mem[addr[5:2]];
        if (cmd == 8'h01 && k >= 4 && k <= 7) return 8'((word >> (8 * (7 - k))) & 32'hFF);
        if (WEL_EN && cmd == 8'h05 && k >= 1 && k <= 3) return {7'b0, pre_wel};
        return 8'h00;
    endfunction

    task automatic do_reset();
        @(negedge p_clk);
        p_reset_n = 1'b0;
        s_css     = 1'b1;
        s_clk     = 1'b0;
        repeat (3) @(negedge p_clk);
        check_val("reset_miso", 32'(s_miso), 32'h00);
        check_val("reset_busy", 32'(s_busy), 32'h0);
        p_reset_n = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hFFFF_FFFF;
        ref_wel = 1'b0;
        repeat (2) @(negedge p_clk);
        $display("reset applied");
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                             input logic [31:0] data, input int nbytes);
        logic [7:0] bytes [8];
        logic       pre_wel;
        logic       in_rng;
        logic       en;
        bytes   = '{cmd, addr[23:16], addr[15:8], addr[7:0],
                    data[31:24], data[23:16], data[15:8], data[7:0]};
        pre_wel = ref_wel;
        @(negedge p_clk);
        s_css = 1'b0;
        repeat (2) @(negedge p_clk);
        for (int k = 1; k <= nbytes; k++) begin
            s_mosi = bytes[k-1];
            s_clk  = 1'b1;
            repeat (4) @(negedge p_clk);
            s_clk  = 1'b0;
            repeat (4) @(negedge p_clk);
            check_val({tag, "_miso"}, 32'(s_miso), 32'(exp_miso(cmd, addr, k, pre_wel)));
            check_val({tag, "_busy"}, 32'(s_busy), 32'(k < 8));
        end
        s_css = 1'b1;
        repeat (3) @(negedge p_clk);
        check_val({tag, "_idle_busy"}, 32'(s_busy), 32'h0);
        check_val({tag, "_idle_miso"}, 32'(s_miso), 32'h00);
        if (nbytes >= 1) begin
            in_rng = (addr[23:6] == 0);
            en     = !WEL_EN || pre_wel;
            if (cmd == 8'h02 && nbytes == 8 && in_rng && en)
                ref_mem[addr[5:2]] = ref_mem[addr[5:2]] & data;
            if (cmd == 8'h20 && nbytes >= 4 && in_rng && en)
                ref_mem[addr[5:2]] = 32'hFFFF_FFFF;
            if (WEL_EN && cmd == 8'h06) ref_wel = 1'b1;
            if (WEL_EN && (cmd == 8'h02 || cmd == 8'h20)) ref_wel = 1'b0;
        end
        $display("frame %s cmd=%h addr=%h data=%h bytes=%0d", tag, cmd, addr, data, nbytes);
    endtask

    initial begin
        logic [7:0]  cmd_tab [7];
        logic [7:0]  rcmd;
        logic [23:0] raddr;
        logic [31:0] rdata;
        int          rn;
        cmd_tab = '{8'h01, 8'h02, 8'h20, 8'h05, 8'h06, 8'h9F, 8'h01};

        do_reset();
        // basic read of erased array
        run_frame("rd_erased", 8'h01, 24'h000000, 32'h0, 8);
        // program and AND-merge
        run_frame("wren1", 8'h06, 24'h0, 32'h0, 1);
        run_frame("prog1", 8'h02, 24'h000000, 32'hFF00FF00, 8);
        run_frame("rd_prog1", 8'h01, 24'h000000, 32'h0, 8);
        run_frame("wren2", 8'h06, 24'h0, 32'h0, 1);
        run_frame("prog2", 8'h02, 24'h000000, 32'h0F0F0F0F, 8);
        run_frame("rd_and", 8'h01, 24'h000000, 32'h0, 8);
        // erase, then an aborted program
        run_frame("wren3", 8'h06, 24'h0, 32'h0, 1);
        run_frame("erase", 8'h20, 24'h000000, 32'h0, 8);
        run_frame("rd_erase", 8'h01, 24'h000000, 32'h0, 8);
        run_frame("wren4", 8'h06, 24'h0, 32'h0, 1);
        run_frame("prog_abort", 8'h02, 24'h000000, 32'h12345678, 6);
        run_frame("rd_abort", 8'h01, 24'h000000, 32'h0, 8);
        // out of range
        run_frame("rd_oor", 8'h01, 24'h000100, 32'h0, 8);
        run_frame("wren5", 8'h06, 24'h0, 32'h0, 1);
        run_frame("prog_oor", 8'h02, 24'h000100, 32'h00000000, 8);
        run_frame("rd_w0", 8'h01, 24'h000000, 32'h0, 8);
        run_frame("rd_w1", 8'h01, 24'h000005, 32'h0, 8);
        run_frame("rd_w15", 8'h01, 24'h00003C, 32'h0, 8);
        // write-enable latch behaviour (unknown commands when not built in)
        run_frame("prog_nowel", 8'h02, 24'h000008, 32'h00000000, 8);
        run_frame("rd_nowel", 8'h01, 24'h000008, 32'h0, 8);
        run_frame("rdsr0", 8'h05, 24'h0, 32'h0, 4);
        run_frame("wren6", 8'h06, 24'h0, 32'h0, 1);
        run_frame("rdsr1", 8'h05, 24'h0, 32'h0, 4);
        run_frame("prog_wel", 8'h02, 24'h000008, 32'h00FF00FF, 8);
        run_frame("rdsr2", 8'h05, 24'h0, 32'h0, 4);
        run_frame("rd_wel", 8'h01, 24'h000008, 32'h0, 8);

        // randomized frames
        for (int t = 0; t < 60; t++) begin
            rcmd = cmd_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) rcmd = 8'($urandom);
            if ($urandom_range(0, 7) == 0) raddr = 24'($urandom) | 24'h000040;
            else                           raddr = {18'b0, 6'($urandom)};
            rdata = $urandom | $urandom;
            rn    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 8;
            run_frame($sformatf("rnd%0d", t), rcmd, raddr, rdata, rn);
        end

        // reset restores the erased array
        do_reset();
        run_frame("rd_after_reset", 8'h01, 24'h000008, 32'h0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
